// File: rtl/dose_sequencer.sv
// dose_sequencer: drives the R, Y and B pigment dispense motors one at a time
// for a single mix order. Each channel runs for dose * TICKS_PER_UNIT prescaler
// ticks and raises a sticky completion flag.
// Optional feature macro: DOSE_GAP_EN. When defined, an all-motors-off gap of
// GAP_TICKS ticks is inserted between R/Y and between Y/B.
//
// Handshake: start is a one-cycle request, honoured only in IDLE with abort
// low. The order is then busy until the cycle after the single-cycle done
// pulse. abort is a synchronous, highest-priority stop back to IDLE that keeps
// the flags already earned.
module dose_sequencer #(
    parameter int DOSE_W         = 8,
    parameter int TICKS_PER_UNIT = 4,
    parameter int GAP_TICKS      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              tick,
    input  logic [DOSE_W-1:0] dose_r,
    input  logic [DOSE_W-1:0] dose_y,
    input  logic [DOSE_W-1:0] dose_b,
    output logic [2:0]        motor,
    output logic [2:0]        flags,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    // One spare bit so the largest dose times the tick multiplier never wraps.
    localparam int CW = DOSE_W + $clog2(TICKS_PER_UNIT) + 1;

`ifdef DOSE_GAP_EN
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_TICKS);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN_R  = 3'd1,
        S_RUN_Y  = 3'd2,
        S_RUN_B  = 3'd3,
`ifdef DOSE_GAP_EN
        S_GAP_RY = 3'd5,
        S_GAP_YB = 3'd6,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DOSE_W-1:0] dose_r_q;
    logic [DOSE_W-1:0] dose_y_q;
    logic [DOSE_W-1:0] dose_b_q;
    logic              last_tick;

    // Tick count for a channel, computed at full counter width.
    function automatic logic [CW-1:0] scaled(input logic [DOSE_W-1:0] d);
        return CW'(d) * CW'(TICKS_PER_UNIT);
    endfunction

    // Motor enable for a channel about to start: off when its dose is zero.
    function automatic logic [2:0] motor_for(input logic [DOSE_W-1:0] d,
                                             input logic [2:0] onehot);
        return (d != '0) ? onehot : 3'b000;
    endfunction

    // The timed state finishes on the tick that takes the counter from 1 to 0.
    assign last_tick = tick && (cnt == CW'(1));

    assign state_dbg = state;

    // Sequencer FSM: all outputs registered so motor enables never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dose_r_q <= '0;
            dose_y_q <= '0;
            dose_b_q <= '0;
            motor    <= 3'b000;
            flags    <= 3'b000;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                motor <= 3'b000;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            dose_r_q <= dose_r;
                            dose_y_q <= dose_y;
                            dose_b_q <= dose_b;
                            flags    <= 3'b000;
                            cnt      <= scaled(dose_r);
                            motor    <= motor_for(dose_r, 3'b100);
                            busy     <= 1'b1;
                            state    <= S_RUN_R;
                        end
                    end
                    S_RUN_R: begin
                        if (dose_r_q == '0 || last_tick) begin
                            flags[2] <= 1'b1;
`ifdef DOSE_GAP_EN
                            cnt   <= GAP_LOAD;
                            motor <= 3'b000;
                            state <= S_GAP_RY;
`else
                            cnt   <= scaled(dose_y_q);
                            motor <= motor_for(dose_y_q, 3'b010);
                            state <= S_RUN_Y;
`endif
                        end else if (tick) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
`ifdef DOSE_GAP_EN
                    S_GAP_RY: begin
                        if (cnt == '0 || last_tick) begin
                            cnt   <= scaled(dose_y_q);
                            motor <= motor_for(dose_y_q, 3'b010);
                            state <= S_RUN_Y;
                        end else if (tick) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
`endif
                    S_RUN_Y: begin
                        if (dose_y_q == '0 || last_tick) begin
                            flags[1] <= 1'b1;
`ifdef DOSE_GAP_EN
                            cnt   <= GAP_LOAD;
                            motor <= 3'b000;
                            state <= S_GAP_YB;
`else
                            cnt   <= scaled(dose_b_q);
                            motor <= motor_for(dose_b_q, 3'b001);
                            state <= S_RUN_B;
`endif
                        end else if (tick) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
`ifdef DOSE_GAP_EN
                    S_GAP_YB: begin
                        if (cnt == '0 || last_tick) begin
                            cnt   <= scaled(dose_b_q);
                            motor <= motor_for(dose_b_q, 3'b001);
                            state <= S_RUN_B;
                        end else if (tick) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
`endif
                    S_RUN_B: begin
                        if (dose_b_q == '0 || last_tick) begin
                            flags[0] <= 1'b1;
                            motor    <= 3'b000;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else if (tick) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        motor <= 3'b000;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dose_sequencer.md
Name: dose_sequencer

Overview:
Sequences the three pigment dispense motors (R, Y, B) for one mix order. Latches three dose amounts on start and drives one motor at a time, for dose × TICKS_PER_UNIT prescaler ticks each. Raises the per-channel completion flags consumed by the top-level mixing FSM. Sits between the dose-computation datapath and the motor drivers, and replaces externally generated flags.

Parameters:
DOSE_W, 8, width of each dose input (units of pigment)
TICKS_PER_UNIT, 4, tick pulses per dose unit; must be >= 1
GAP_TICKS, 2, ticks of all-motors-off between channels; used only with DOSE_GAP_EN

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin an order; sampled only in IDLE
abort  input  1  synchronous stop; any state to IDLE
tick  input  1  prescaler enable pulse; all dose timing counts these
dose_r  input  DOSE_W  red dose, latched on accepted start
dose_y  input  DOSE_W  yellow dose, latched on accepted start
dose_b  input  DOSE_W  blue dose, latched on accepted start
motor  output  3  one-hot motor enables; [2]=R, [1]=Y, [0]=B, 000=all off
flags  output  3  sticky channel-done flags; [2]=R, [1]=Y, [0]=B
busy  output  1  high while an order is in progress
done  output  1  one-cycle pulse when all three channels are complete

Behaviour:
- Reset (asynchronous, active-low; clock clk): state=IDLE; dose registers and counter = 0; motor=000, flags=000, busy=0, done=0. Takes effect immediately, without a clock edge, including mid-dispense.
- States: IDLE, RUN_R, RUN_Y, RUN_B, DONE, plus GAP_RY and GAP_YB when DOSE_GAP_EN is defined.
- IDLE: start=1 and abort=0 at the edge does all of the following:
  - latch dose_r/y/b
  - flags <= 000
  - load counter = dose_r × TICKS_PER_UNIT
  - go to RUN_R
- start is ignored in every state other than IDLE.
- RUN_x with latched dose != 0:
  - motor = one-hot for channel x, asserted from the first cycle in the state.
  - Counter decrements on each clk edge where tick=1.
  - At the edge where tick=1 and counter==1: set flags[x], load the next channel's counter, move to the next state.
  - Motor is therefore on for exactly dose × TICKS_PER_UNIT ticks.
- RUN_x with latched dose == 0: stays exactly one clk cycle with motor=000, sets flags[x] at exit, does not wait for tick.
- Order is RUN_R -> RUN_Y -> RUN_B -> DONE. Without the gap feature, the next motor asserts in the cycle immediately after the previous one drops. At most one motor bit is ever high.
- DONE: one cycle with done=1, flags=111, busy=1; then IDLE. busy goes to 0 in IDLE.
- busy=1 in every state except IDLE.
- abort=1 at any edge:
  - next state IDLE; motor=000 from the next cycle
  - flags keep the values already earned
  - done is not pulsed
  - abort wins over start and over tick completion in the same cycle
- Counter width: DOSE_W + clog2(TICKS_PER_UNIT) + 1. The product is computed without overflow. Maximum dose 2^DOSE_W - 1 is legal.
- motor and flags are registered, or decoded solely from registered state and dose, so they are glitch-free.
- Unknown or illegal state encoding: next state IDLE, motor=000.

Optional Feature:
DOSE_GAP_EN
- Defined: GAP_RY is inserted after RUN_R and GAP_YB after RUN_Y, not after RUN_B. Each gap holds motor=000 and busy=1 for GAP_TICKS ticks, using the same counter/tick rule. GAP_TICKS=0 makes a gap last one clk cycle. Gaps are still inserted around zero-dose channels. abort is honoured in gap states.
- Undefined: no gap states exist, GAP_TICKS is unused, and channels are back-to-back.

Test Plan:
- Back-to-back run: tick tied 1, TICKS_PER_UNIT=4, dose 2/1/3, start pulse.
  - motor: 100 for 8 cycles, 010 for 4, 001 for 12
  - flags: 100, then 110, then 111
  - done high one cycle after the last motor cycle; busy low the cycle after
- Zero yellow dose: dose 1/0/1, tick=1.
  - motor: 100 ×4, 000 ×1 (flags -> 110), 001 ×4
  - done pulses once
- Slow tick: tick every 3rd clk, dose_r=1, TICKS_PER_UNIT=4.
  - motor[2] high ~12 clks, dropping on the edge of the 4th tick
  - mid-order start pulses ignored; latched doses unchanged when inputs change
- Abort: assert abort during RUN_Y (dose 2/2/2).
  - next cycle motor=000, flags=100, busy=0, done never pulses
  - new start then restarts from RUN_R with flags cleared
- Async reset: drop reset mid RUN_R with no clock edge.
  - motor/flags/busy/done = 0 immediately
  - on release, block is in IDLE and accepts start
- With DOSE_GAP_EN, GAP_TICKS=2, tick=1, dose 1/1/1: motor sequence 100×4, 000×2, 010×4, 000×2, 001×4, then done.
